// File: rtl/pll_cen_gen.sv
// rtl/pll_cen_gen.sv - multi-channel fractional clock-enable generator with settle/lock indication
module pll_cen_gen #(
    parameter int NUM_CH      = 4,
    parameter int ACC_W       = 24,
    parameter int LOCK_CYCLES = 256,
    parameter logic [NUM_CH*ACC_W-1:0] DEFAULT_INC = (NUM_CH*ACC_W)'(24'hA3D70A),
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] ce_fall,
    output logic              locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {S_RESET, S_SETTLE, S_LOCKED} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              ack_d;
    logic              accept, ch_ok, cfg_hit, locked_next;
    logic [ACC_W-1:0]  acc [NUM_CH];
    logic [ACC_W-1:0]  inc [NUM_CH];
    logic [ACC_W:0]    sum [NUM_CH];
    logic [NUM_CH-1:0] raw_ce, raw_fall;

    assign accept      = cfg_valid & cfg_ready;
    assign ch_ok       = {1'b0, cfg_ch} < (CH_W+1)'(NUM_CH);
    assign cfg_hit     = accept & ch_ok;
    assign locked_next = (state_next == S_LOCKED);

    always_ff @(posedge refclk) begin
        if (rst) begin
            state <= S_RESET;
            cnt   <= '0;
            ack_d <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ack_d <= accept;
        end
    end

    // A valid-channel accept always restarts the settle count, even mid-settle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_RESET: begin
                state_next = S_SETTLE;
                cnt_next   = '0;
            end
            S_SETTLE: begin
                if (cnt == CNT_LAST) begin
                    state_next = S_LOCKED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_LOCKED: ;
            default: state_next = S_RESET;
        endcase
        if (cfg_hit) begin
            state_next = S_SETTLE;
            cnt_next   = '0;
        end
    end

    always_comb begin
        locked    = (state == S_LOCKED);
        cfg_ready = (state != S_RESET) & ~ack_d;
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            sum[k]      = {1'b0, acc[k]} + {1'b0, inc[k]};
            raw_ce[k]   = sum[k][ACC_W];
            raw_fall[k] = ~acc[k][ACC_W-1] & sum[k][ACC_W-1] & ~sum[k][ACC_W];
        end
    end

    // Accumulators free-run while unlocked; only the strobes are gated.
    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc[k] <= '0;
                inc[k] <= DEFAULT_INC[k*ACC_W +: ACC_W];
            end
            ce      <= '0;
            ce_fall <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (cfg_hit && cfg_ch == CH_W'(k)) begin
                    acc[k] <= cfg_phase;
                    inc[k] <= cfg_inc;
                end else begin
                    acc[k] <= sum[k][ACC_W-1:0];
                end
            end
            ce      <= raw_ce & {NUM_CH{locked_next}};
            ce_fall <= raw_fall & {NUM_CH{locked_next}};
        end
    end

endmodule

// File: tb/tb_pll_cen_gen.sv
// tb/tb_pll_cen_gen.sv - directed bench for pll_cen_gen (full-size instance plus a tiny 3-channel instance)
module tb_pll_cen_gen;

    logic refclk = 1'b0;
    always #5 refclk = ~refclk;

    logic        rst0, v0, rdy0, lk0;
    logic [1:0]  ch0;
    logic [23:0] inc0, ph0;
    logic [3:0]  ce0, cf0;

    logic        rst1, v1, rdy1, lk1;
    logic [1:0]  ch1;
    logic [3:0]  inc1, ph1;
    logic [2:0]  ce1, cf1;

    pll_cen_gen u0 (
        .refclk(refclk), .rst(rst0), .cfg_valid(v0), .cfg_ready(rdy0), .cfg_ch(ch0),
        .cfg_inc(inc0), .cfg_phase(ph0), .ce(ce0), .ce_fall(cf0), .locked(lk0)
    );

    pll_cen_gen #(.NUM_CH(3), .ACC_W(4), .LOCK_CYCLES(2), .DEFAULT_INC(12'h006)) u1 (
        .refclk(refclk), .rst(rst1), .cfg_valid(v1), .cfg_ready(rdy1), .cfg_ch(ch1),
        .cfg_inc(inc1), .cfg_phase(ph1), .ce(ce1), .ce_fall(cf1), .locked(lk1)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [1:0] ch;
        logic [3:0] inc;
        logic [3:0] ph;
        logic [2:0] ce;
        logic [2:0] cf;
        logic       lk;
        logic       rdy;
    } vec_t;

    vec_t tv[19];

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] c, input logic [3:0] i,
                                input logic [3:0] p, input logic [2:0] e, input logic [2:0] f,
                                input logic l, input logic y);
        vec_t t;
        t.rst = r; t.valid = v; t.ch = c; t.inc = i; t.ph = p;
        t.ce = e; t.cf = f; t.lk = l; t.rdy = y;
        return t;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic do_cfg(input logic [1:0] c, input logic [23:0] i, input logic [23:0] p);
        int w;
        w = 0;
        while (!rdy0 && w < 10) begin
            tick();
            w++;
        end
        v0 = 1'b1; ch0 = c; inc0 = i; ph0 = p;
        tick();
        v0 = 1'b0;
    endtask

    task automatic wait_lock(input int start, output int n);
        n = start;
        while (!lk0 && n < 400) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, c, last, bad, oth, seen, fl;
        logic prev;

        rst0 = 1'b1; v0 = 1'b0; ch0 = '0; inc0 = '0; ph0 = '0;
        rst1 = 1'b1; v1 = 1'b0; ch1 = '0; inc1 = '0; ph1 = '0;

        // small instance: ch0 inc=6 mod 16, lock after 2 settle cycles
        tv[0]  = mk(1, 0, 0, 4'h0, 4'h0, 3'b000, 3'b000, 0, 0);
        tv[1]  = mk(1, 0, 0, 4'h0, 4'h0, 3'b000, 3'b000, 0, 0);
        tv[2]  = mk(0, 0, 0, 4'h0, 4'h0, 3'b000, 3'b000, 0, 1);
        tv[3]  = mk(0, 0, 0, 4'h0, 4'h0, 3'b000, 3'b000, 0, 1);
        tv[4]  = mk(0, 0, 0, 4'h0, 4'h0, 3'b001, 3'b000, 1, 1);
        tv[5]  = mk(0, 0, 0, 4'h0, 4'h0, 3'b000, 3'b001, 1, 1);
        tv[6]  = mk(0, 0, 0, 4'h0, 4'h0, 3'b000, 3'b000, 1, 1);
        tv[7]  = mk(0, 0, 0, 4'h0, 4'h0, 3'b001, 3'b000, 1, 1);
        tv[8]  = mk(0, 1, 1, 4'h4, 4'hE, 3'b000, 3'b000, 0, 0);
        tv[9]  = mk(0, 0, 0, 4'h0, 4'h0, 3'b000, 3'b000, 0, 1);
        tv[10] = mk(0, 0, 0, 4'h0, 4'h0, 3'b000, 3'b000, 1, 1);
        tv[11] = mk(0, 0, 0, 4'h0, 4'h0, 3'b000, 3'b011, 1, 1);
        tv[12] = mk(0, 1, 3, 4'hF, 4'h0, 3'b001, 3'b000, 1, 0);
        tv[13] = mk(0, 0, 0, 4'h0, 4'h0, 3'b010, 3'b001, 1, 1);
        tv[14] = mk(1, 1, 2, 4'h1, 4'h0, 3'b000, 3'b000, 0, 0);
        tv[15] = mk(0, 0, 0, 4'h0, 4'h0, 3'b000, 3'b000, 0, 1);
        tv[16] = mk(0, 0, 0, 4'h0, 4'h0, 3'b000, 3'b000, 0, 1);
        tv[17] = mk(0, 0, 0, 4'h0, 4'h0, 3'b001, 3'b000, 1, 1);
        tv[18] = mk(0, 0, 0, 4'h0, 4'h0, 3'b000, 3'b001, 1, 1);

        for (int i = 0; i < 19; i++) begin
            rst1 = tv[i].rst; v1 = tv[i].valid; ch1 = tv[i].ch; inc1 = tv[i].inc; ph1 = tv[i].ph;
            tick();
            chk($sformatf("vec%0d_ce", i), ce1, tv[i].ce);
            chk($sformatf("vec%0d_ce_fall", i), cf1, tv[i].cf);
            chk($sformatf("vec%0d_locked", i), lk1, tv[i].lk);
            chk($sformatf("vec%0d_cfg_ready", i), rdy1, tv[i].rdy);
        end
        v1 = 1'b0;

        // full instance: reset state and lock latency
        for (int i = 0; i < 3; i++) tick();
        chk("rst_ce", ce0, 0);
        chk("rst_ce_fall", cf0, 0);
        chk("rst_locked", lk0, 0);
        chk("rst_cfg_ready", rdy0, 0);
        rst0 = 1'b0;
        tick();
        chk("settle_cfg_ready", rdy0, 1);
        wait_lock(1, n);
        chk("lock_latency", n, 257);

        // default ch0 = 0.64 of refclk
        c = 0; last = -1; bad = 0; oth = 0; fl = 0;
        for (int i = 0; i < 50000; i++) begin
            tick();
            if (ce0[0]) begin
                if (last >= 0 && (i - last < 1 || i - last > 2)) bad++;
                last = i;
                c++;
            end
            if (ce0[3:1] != 0 || cf0[3:1] != 0) oth++;
            if (!lk0) fl++;
        end
        chk("ch0_count_in_32000_pm1", (c >= 31999 && c <= 32001) ? 1 : 0, 1);
        chk("ch0_bad_gaps", bad, 0);
        chk("ch123_silent", oth, 0);
        chk("lock_held", fl, 0);

        // ch1 half-rate: ce on even, ce_fall on odd cycles after the load
        do_cfg(2'd1, 24'h800000, 24'h000000);
        chk("cfg1_locked_drop", lk0, 0);
        chk("cfg1_ready_low", rdy0, 0);
        tick();
        chk("cfg1_ready_back", rdy0, 1);
        wait_lock(1, n);
        chk("cfg1_relock", n, 256);
        chk("cfg1_first_ce", ce0[1], 1);
        chk("cfg1_first_fall", cf0[1], 0);
        bad = 0; prev = ce0[1];
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ce0[1] == cf0[1] || ce0[1] == prev) bad++;
            prev = ce0[1];
        end
        chk("cfg1_alternation", bad, 0);

        // ch2 quarter-rate from phase 0xC00000: carry 1, 5, 9... edges after load
        do_cfg(2'd2, 24'h400000, 24'hC00000);
        wait_lock(0, n);
        chk("cfg2_relock", n, 256);
        chk("cfg2_no_ce_at_lock", ce0[2], 0);
        tick();
        chk("cfg2_first_ce", ce0[2], 1);
        tick();
        tick();
        chk("cfg2_first_fall", cf0[2], 1);

        // reconfig 100 cycles into the settle restarts the count
        do_cfg(2'd3, 24'h000000, 24'h000000);
        chk("cfg3a_locked_drop", lk0, 0);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (lk0) seen++;
        end
        chk("midsettle_no_lock", seen, 0);
        do_cfg(2'd3, 24'hFFFFFF, 24'h000000);
        wait_lock(0, n);
        chk("midsettle_relock", n, 256);

        // near-full-scale increment: carry every cycle, fall never
        c = 0; fl = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            c += ce0[3];
            fl += cf0[3];
        end
        chk("ffffff_ce_count", c, 1000);
        chk("ffffff_fall_count", fl, 0);

        // zero increment freezes the channel
        do_cfg(2'd3, 24'h000000, 24'h123456);
        wait_lock(0, n);
        chk("zero_inc_relock", n, 256);
        c = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            c += ce0[3] + cf0[3];
        end
        chk("zero_inc_silent", c, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
